// File: rtl/spart_bus_if_if.sv
// SPART processor-bus control group: chip select, direction, address and the status lines back to the CPU.
// The 8-bit databus stays a plain inout on the responder so it can resolve against the CPU driver.
interface spart_bus_if_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;
    logic       bus_oe_c;

    modport master (
        output iocs,
        output iorw,
        output ioaddr,
        input  rda,
        input  tbr,
        input  bus_oe_c
    );

    modport slave (
        input  iocs,
        input  iorw,
        input  ioaddr,
        output rda,
        output tbr,
        output bus_oe_c
    );
endinterface

// File: rtl/spart_bus_if.sv
// SPART bus responder: TX holding register, RX buffer/status, 16-bit baud divisor and 16x baud enable.
// Define SPART_RX_FIFO_EN to replace the single RX buffer with an RX_FIFO_DEPTH-entry FIFO.
module spart_bus_if #(
    parameter logic [15:0] DEF_DIVISOR = 16'd161
`ifdef SPART_RX_FIFO_EN
    , parameter int unsigned RX_FIFO_DEPTH = 4
`endif
) (
    input  logic          clk,
    input  logic          rst,
    spart_bus_if_if.slave bus,
    inout  wire  [7:0]    io_databus,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_start,
    input  logic          i_tx_busy,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_valid,
    output logic          o_baud_en
);

    localparam logic [1:0] A_BUF  = 2'b00;
    localparam logic [1:0] A_STAT = 2'b01;
    localparam logic [1:0] A_DBL  = 2'b10;
    localparam logic [1:0] A_DBH  = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE = 2'b00,
        TX_PEND = 2'b01,
        TX_BUSY = 2'b10
    } tx_state_e;

    logic        r_iocs_q;
    logic        w_acc;
    logic        w_wr;
    logic        w_rd;
    logic [1:0]  w_addr;
    logic [7:0]  w_wdata;

    logic [15:0] r_divisor;
    logic [15:0] r_baud_cnt;
    logic        r_reload;
    logic        r_baud_en;

    tx_state_e   r_tx_state;
    tx_state_e   w_tx_state_nxt;
    logic        r_tbr;
    logic        w_tbr_nxt;
    logic        r_tx_start;
    logic        w_tx_start_nxt;
    logic [7:0]  r_tx_data;
    logic [7:0]  w_tx_data_nxt;

    logic        r_rda;
    logic        r_overrun;
    logic        w_rx_pop;
    logic        w_ovr_set;
    logic        w_stat_clr;
    logic [7:0]  w_rx_head;

    logic        w_bus_oe;
    logic [7:0]  w_rd_mux;

    // One access per iocs assertion: only the rising edge of chip select has side effects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iocs_q <= 1'b0;
        end else begin
            r_iocs_q <= bus.iocs;
        end
    end

    assign w_acc      = bus.iocs & ~r_iocs_q;
    assign w_wr       = w_acc & ~bus.iorw;
    assign w_rd       = w_acc & bus.iorw;
    assign w_addr     = bus.ioaddr;
    assign w_wdata    = io_databus;
    assign w_stat_clr = w_rd && (w_addr == A_STAT);

    // Baud generator; a high-byte write schedules a silent reload so the new rate starts cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divisor  <= DEF_DIVISOR;
            r_baud_cnt <= DEF_DIVISOR;
            r_reload   <= 1'b0;
            r_baud_en  <= 1'b0;
        end else begin
            if (w_wr && (w_addr == A_DBL)) begin
                r_divisor[7:0] <= w_wdata;
            end
            if (w_wr && (w_addr == A_DBH)) begin
                r_divisor[15:8] <= w_wdata;
            end
            r_reload <= w_wr && (w_addr == A_DBH);
            if (r_reload) begin
                r_baud_cnt <= r_divisor;
                r_baud_en  <= 1'b0;
            end else if (r_baud_cnt == 16'd0) begin
                r_baud_cnt <= r_divisor;
                r_baud_en  <= 1'b1;
            end else begin
                r_baud_cnt <= r_baud_cnt - 16'd1;
                r_baud_en  <= 1'b0;
            end
        end
    end

    // TX handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tbr      <= 1'b1;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tbr      <= w_tbr_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
        end
    end

    // TX next state: a write is accepted only while idle, otherwise dropped without touching tx_data.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tbr_nxt      = r_tbr;
        w_tx_start_nxt = r_tx_start;
        w_tx_data_nxt  = r_tx_data;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_wr && (w_addr == A_BUF)) begin
                    w_tx_state_nxt = TX_PEND;
                    w_tx_data_nxt  = w_wdata;
                    w_tbr_nxt      = 1'b0;
                    w_tx_start_nxt = 1'b1;
                end
            end
            TX_PEND: begin
                w_tx_start_nxt = 1'b1;
                if (i_tx_busy) begin
                    w_tx_start_nxt = 1'b0;
                    w_tx_state_nxt = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (!i_tx_busy) begin
                    w_tbr_nxt      = 1'b1;
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
                w_tbr_nxt      = 1'b1;
                w_tx_start_nxt = 1'b0;
            end
        endcase
    end

`ifdef SPART_RX_FIFO_EN
    localparam int unsigned RX_AW = $clog2(RX_FIFO_DEPTH);
    localparam int unsigned RX_PW = RX_AW + 1;

    logic [7:0]       r_fifo [RX_FIFO_DEPTH];
    logic [RX_PW-1:0] r_wr_ptr;
    logic [RX_PW-1:0] r_rd_ptr;
    logic [RX_PW-1:0] w_wr_nxt;
    logic [RX_PW-1:0] w_rd_nxt;
    logic             w_empty;
    logic             w_full;
    logic             w_push;

    // Extra pointer bit separates full from empty; a pop frees the slot for a same-cycle push.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[RX_AW] != r_rd_ptr[RX_AW]) &&
                       (r_wr_ptr[RX_AW-1:0] == r_rd_ptr[RX_AW-1:0]);
    assign w_rx_pop  = w_rd && (w_addr == A_BUF) && !w_empty;
    assign w_push    = i_rx_valid && (!w_full || w_rx_pop);
    assign w_ovr_set = i_rx_valid && w_full && !w_rx_pop;
    assign w_wr_nxt  = r_wr_ptr + RX_PW'(w_push);
    assign w_rd_nxt  = r_rd_ptr + RX_PW'(w_rx_pop);
    assign w_rx_head = r_fifo[r_rd_ptr[RX_AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rda    <= 1'b0;
            for (int i = 0; i < int'(RX_FIFO_DEPTH); i++) begin
                r_fifo[i] <= 8'h00;
            end
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_rda    <= (w_wr_nxt != w_rd_nxt);
            if (w_push) begin
                r_fifo[r_wr_ptr[RX_AW-1:0]] <= i_rx_data;
            end
        end
    end
`else
    logic [7:0] r_rx_buf;

    // Single buffer: newest byte always wins; losing an unread byte is an overrun.
    assign w_rx_pop  = w_rd && (w_addr == A_BUF) && r_rda;
    assign w_ovr_set = i_rx_valid && r_rda && !w_rx_pop;
    assign w_rx_head = r_rx_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_buf <= 8'h00;
            r_rda    <= 1'b0;
        end else if (i_rx_valid) begin
            r_rx_buf <= i_rx_data;
            r_rda    <= 1'b1;
        end else if (w_rx_pop) begin
            r_rda    <= 1'b0;
        end
    end
`endif

    // Sticky overrun; a new overrun in the clearing cycle keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_ovr_set | (r_overrun & ~w_stat_clr);
        end
    end

    always_comb begin
        w_rd_mux = 8'h00;
        case (w_addr)
            A_BUF:  w_rd_mux = w_rx_head;
            A_STAT: w_rd_mux = {5'b00000, r_overrun, r_rda, r_tbr};
            A_DBL:  w_rd_mux = r_divisor[7:0];
            A_DBH:  w_rd_mux = r_divisor[15:8];
            default: w_rd_mux = 8'h00;
        endcase
    end

    // Read data is driven for the whole chip-select window, released during reset.
    assign w_bus_oe     = bus.iocs & bus.iorw & ~rst;
    assign io_databus   = w_bus_oe ? w_rd_mux : 8'hzz;
    assign bus.bus_oe_c = w_bus_oe;
    assign bus.rda      = r_rda;
    assign bus.tbr      = r_tbr;

    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_baud_en  = r_baud_en;

endmodule
